// File: rtl/enigma_ctrl.sv
// enigma_ctrl -- command sequencer for the Enigma rotor datapath.
//
// Accepts byte-level commands, holds the three rotor positions, applies the
// historical stepping rule (with the middle-rotor double-step) before every
// character, launches the substitution datapath and returns its result.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cmd_valid/op/data      command handshake input (op 3 bits, data 5 bits)
//   cmd_ready              high only while IDLE
//   dp_char, dp_pos_r/m/l  registered character and rotor offsets to datapath
//   dp_start               one-cycle launch strobe to the datapath
//   dp_result              datapath output, sampled DP_LATENCY cycles later
//   out_char, out_valid    last result and its one-cycle update pulse
//   err                    sticky error flag (cleared by RESET_POS or reset)
module enigma_ctrl #(
  parameter int DP_LATENCY = 2,
  parameter int NOTCH_R    = 21,
  parameter int NOTCH_M    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  input  logic [4:0] cmd_data,
  output logic       cmd_ready,
  output logic [4:0] dp_char,
  output logic [4:0] dp_pos_r,
  output logic [4:0] dp_pos_m,
  output logic [4:0] dp_pos_l,
  output logic       dp_start,
  input  logic [4:0] dp_result,
  output logic [4:0] out_char,
  output logic       out_valid,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam logic [2:0] OP_LOAD_R  = 3'd1;
  localparam logic [2:0] OP_LOAD_M  = 3'd2;
  localparam logic [2:0] OP_LOAD_L  = 3'd3;
  localparam logic [2:0] OP_ENCRYPT = 3'd4;
  localparam logic [2:0] OP_RST_POS = 3'd5;

  localparam logic [4:0] NOTCH_R_V = 5'(NOTCH_R);
  localparam logic [4:0] NOTCH_M_V = 5'(NOTCH_M);
  // Last WAIT count value; unused when the datapath is combinational.
  localparam logic [2:0] WAIT_LAST = 3'((DP_LATENCY > 0) ? (DP_LATENCY - 1) : 0);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] wait_cnt;
  logic       capture;
  logic       accept;
  logic       operand_ok;

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v == 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  assign accept     = cmd_valid & cmd_ready;
  assign operand_ok = (cmd_data < 5'd26);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    dp_start  = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_op == OP_ENCRYPT && operand_ok) state_nxt = ST_STEP;
      end
      ST_STEP:  state_nxt = ST_DRIVE;
      ST_DRIVE: begin
        dp_start = 1'b1;
        if (DP_LATENCY == 0) begin
          capture   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          capture   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command execution, rotor stepping and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= 3'd0;
      dp_char   <= 5'd0;
      dp_pos_r  <= 5'd0;
      dp_pos_m  <= 5'd0;
      dp_pos_l  <= 5'd0;
      out_char  <= 5'd0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      wait_cnt  <= (state == ST_WAIT) ? wait_cnt + 3'd1 : 3'd0;
      out_valid <= capture;
      if (capture) out_char <= dp_result;

      if (accept) begin
        case (cmd_op)
          OP_LOAD_R:  if (operand_ok) dp_pos_r <= cmd_data; else err <= 1'b1;
          OP_LOAD_M:  if (operand_ok) dp_pos_m <= cmd_data; else err <= 1'b1;
          OP_LOAD_L:  if (operand_ok) dp_pos_l <= cmd_data; else err <= 1'b1;
          OP_ENCRYPT: if (operand_ok) dp_char  <= cmd_data; else err <= 1'b1;
          OP_RST_POS: begin
            dp_pos_r <= 5'd0;
            dp_pos_m <= 5'd0;
            dp_pos_l <= 5'd0;
            err      <= 1'b0;
          end
          3'd6, 3'd7: err <= 1'b1;
          default: ;
        endcase
      end

      // Stepping decisions use the pre-step positions; a middle rotor sitting
      // on its notch carries itself and the left rotor (double-step).
      if (state == ST_STEP) begin
        dp_pos_r <= inc26(dp_pos_r);
        if (dp_pos_m == NOTCH_M_V) begin
          dp_pos_m <= inc26(dp_pos_m);
          dp_pos_l <= inc26(dp_pos_l);
        end else if (dp_pos_r == NOTCH_R_V) begin
          dp_pos_m <= inc26(dp_pos_m);
        end
      end
    end
  end

endmodule

// File: tb/tb_enigma_ctrl.sv
module tb_enigma_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [4:0] cmd_data = 5'd0;
  logic       cmd_ready;
  logic [4:0] dp_char, dp_pos_r, dp_pos_m, dp_pos_l;
  logic       dp_start;
  logic [4:0] dp_result;
  logic [4:0] out_char;
  logic       out_valid;
  logic       err;

  int vectors = 0;
  int miscompares = 0;

  // Bench model of the controller.
  int mr = 0, mm = 0, ml = 0, mc = 0;
  logic merr = 1'b0;
  logic [14:0] posq[$];
  logic [4:0]  outq[$];

  enigma_ctrl #(.DP_LATENCY(2), .NOTCH_R(21), .NOTCH_M(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .dp_char(dp_char), .dp_pos_r(dp_pos_r), .dp_pos_m(dp_pos_m), .dp_pos_l(dp_pos_l),
    .dp_start(dp_start), .dp_result(dp_result),
    .out_char(out_char), .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int stub_fn(int c, int r, int m, int l);
    return (c + 6 + r + m + l) % 26;
  endfunction

  // Two-cycle datapath stub; outside its valid cycle it presents 30.
  logic [4:0] stub_s1 = 5'd30;
  logic [4:0] stub_s2 = 5'd30;
  always @(posedge clk) begin
    stub_s1 <= dp_start ? 5'(stub_fn(int'(dp_char), int'(dp_pos_r), int'(dp_pos_m), int'(dp_pos_l)))
                        : 5'd30;
    stub_s2 <= stub_s1;
  end
  assign dp_result = stub_s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: compare launches and results as the DUT produces them.
  always @(negedge clk) begin
    if (dp_start) begin
      chk("launch_expected", 32'(posq.size() != 0), 1);
      if (posq.size() != 0) chk("launch_pos", 32'({dp_pos_l, dp_pos_m, dp_pos_r}), 32'(posq.pop_front()));
    end
    if (out_valid) begin
      chk("result_expected", 32'(outq.size() != 0), 1);
      if (outq.size() != 0) chk("out_char", 32'(out_char), 32'(outq.pop_front()));
    end
  end

  task automatic model_cmd(input int op, input int d);
    int nr, nm, nl;
    case (op)
      1: if (d < 26) mr = d; else merr = 1'b1;
      2: if (d < 26) mm = d; else merr = 1'b1;
      3: if (d < 26) ml = d; else merr = 1'b1;
      4: if (d < 26) begin
           mc = d;
           nr = (mr + 1) % 26; nm = mm; nl = ml;
           if (mm == 4) begin nm = (mm + 1) % 26; nl = (ml + 1) % 26; end
           else if (mr == 21) nm = (mm + 1) % 26;
           mr = nr; mm = nm; ml = nl;
           posq.push_back({5'(ml), 5'(mm), 5'(mr)});
           outq.push_back(5'(stub_fn(mc, mr, mm, ml)));
         end else merr = 1'b1;
      5: begin mr = 0; mm = 0; ml = 0; merr = 1'b0; end
      6, 7: merr = 1'b1;
      default: ;
    endcase
  endtask

  // Caller is always at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input int op, input int d);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = 3'(op); cmd_data = 5'(d);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model_cmd(op, d);
  endtask

  task automatic drain();
    int n = 0;
    while ((outq.size() != 0 || !cmd_ready) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(outq.size()), 0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_r"}, 32'(dp_pos_r), 32'(mr));
    chk({tag, "_m"}, 32'(dp_pos_m), 32'(mm));
    chk({tag, "_l"}, 32'(dp_pos_l), 32'(ml));
    chk({tag, "_err"}, 32'(err), 32'(merr));
    chk({tag, "_char"}, 32'(dp_char), 32'(mc));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_start", 32'(dp_start), 0);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_ochar", 32'(out_char), 0);
    check_model("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. First character: launch at 0/0/1, result 7 four edges after accept
    send(4, 0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        chk("t1_start", 32'(dp_start), 1);
        chk("t1_pos", 32'({dp_pos_l, dp_pos_m, dp_pos_r}), 32'({5'd0, 5'd0, 5'd1}));
      end
      chk("t1_ovalid", 32'(out_valid), 32'(k == 4));
      if (k == 4) chk("t1_ochar", 32'(out_char), 7);
    end

    // 2. Right-notch turnover
    send(1, 21);
    send(2, 0);
    check_model("t2_load");
    send(4, 3);
    drain();
    chk("t2_pos", 32'({dp_pos_l, dp_pos_m, dp_pos_r}), 32'({5'd0, 5'd1, 5'd22}));

    // 3. Double-step, back-to-back characters
    send(3, 0);
    send(2, 3);
    send(1, 21);
    send(4, 10);
    send(4, 11);
    drain();
    chk("t3_pos", 32'({dp_pos_l, dp_pos_m, dp_pos_r}), 32'({5'd1, 5'd5, 5'd23}));

    // 4. Wrap of both right and middle
    send(1, 25);
    send(2, 25);
    send(4, 25);
    drain();
    chk("t4_r", 32'(dp_pos_r), 0);
    chk("t4_m", 32'(dp_pos_m), 25);
    check_model("t4");

    // 5. Errors
    send(1, 26);
    chk("t5_err", 32'(err), 1);
    chk("t5_r", 32'(dp_pos_r), 0);
    send(4, 27);
    chk("t5_badenc_ready", 32'(cmd_ready), 1);
    check_model("t5_badenc");
    send(6, 0);
    chk("t5_op6_err", 32'(err), 1);
    send(5, 0);
    chk("t5_clr_err", 32'(err), 0);
    check_model("t5_clr");

    // 6a. Held command during a busy character is taken once
    send(2, 7);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = 5'd2;
    @(posedge clk); #1;
    model_cmd(4, 2);
    cmd_op = 3'd3; cmd_data = 5'd9;
    for (int k = 1; k <= 5; k++) begin
      chk("t6_ready", 32'(cmd_ready), 32'(k == 5));
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    model_cmd(3, 9);
    @(posedge clk); #1;
    chk("t6_start_idle", 32'(dp_start), 0);
    check_model("t6_held");

    // 6b. Reset during WAIT aborts the character
    send(4, 5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    void'(outq.pop_back());
    mr = 0; mm = 0; ml = 0; mc = 0; merr = 1'b0;
    chk("t6_rst_ready", 32'(cmd_ready), 1);
    chk("t6_rst_ovalid", 32'(out_valid), 0);
    check_model("t6_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_rst_idle", 32'(cmd_ready), 1);
    chk("t6_rst_ochar", 32'(out_char), 0);

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/enigma_ctrl.md
# enigma_ctrl

Command sequencer for the Enigma rotor datapath. Accepts byte-level commands from the pad-side input logic, holds the three rotor positions, applies the historical stepping rule (including middle-rotor double-step) before each character, then drives the substitution datapath and returns its result. It sits between the chip-level input decode and the rotor/reflector path inside the top-level Enigma core.

## Interface

**Parameters**

- `DP_LATENCY`, default 2: cycles from the `dp_start` cycle until `dp_result` is valid. Legal range 0..7.
- `NOTCH_R`, default 21: right-rotor turnover position (V).
- `NOTCH_M`, default 4: middle-rotor turnover position (E).

**Ports**

- `clk`  in  1: clock. All state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: a command is presented.
- `cmd_op`  in  3: opcode.
- `cmd_data`  in  5: operand, a letter index 0..25.
- `cmd_ready`  out  1: high only in IDLE. A command is accepted on a rising edge where `cmd_valid` and `cmd_ready` are both high.
- `dp_char`  out  5: registered character to the datapath.
- `dp_pos_r`, `dp_pos_m`, `dp_pos_l`  out  5 each: registered rotor offsets.
- `dp_start`  out  1: one-cycle launch strobe to the datapath.
- `dp_result`  in  5: datapath output.
- `out_char`  out  5: last result, held until the next capture.
- `out_valid`  out  1: one-cycle pulse when `out_char` updates.
- `err`  out  1: sticky error flag.

## Operation

**Opcodes**

- 0 NOP: no effect.
- 1 LOAD_R, 2 LOAD_M, 3 LOAD_L: the named position takes `cmd_data` on the accepting edge. State stays IDLE.
- 4 ENCRYPT: latch `cmd_data` into `dp_char` and go to STEP.
- 5 RESET_POS: all positions become 0 and `err` clears.
- 6, 7: invalid. The command is accepted and ignored, and `err` is set.
- Operand of 26..31 on LOAD or ENCRYPT: the command is accepted and ignored, `err` is set, and positions and `dp_char` are unchanged.

**States**

- IDLE: `cmd_ready`=1.
  - ENCRYPT with a legal operand → STEP.
  - All other commands → IDLE.
- STEP, 1 cycle: positions update on the exit edge. The right rotor always steps. The rule below uses the pre-step values:
  - if `pos_m`==NOTCH_M: M and L both step (double-step);
  - else if `pos_r`==NOTCH_R: M steps.
  - All increments are mod 26 (25→0).
  - Next state is DRIVE.
- DRIVE, 1 cycle: `dp_start`=1.
  - Next state is WAIT, or CAPTURE when DP_LATENCY=0.
- WAIT, DP_LATENCY cycles: a 3-bit counter runs. Positions and `dp_char` are frozen.
- CAPTURE: on the edge ending the last WAIT cycle (or the DRIVE cycle when DP_LATENCY=0):
  - `out_char`←`dp_result`;
  - `out_valid`=1 for the following cycle;
  - state→IDLE.
- `out_valid` and `cmd_ready` are high together in that cycle. A new command may be accepted then.

**Reset values**

- State IDLE.
- `cmd_ready`=1.
- All positions, `dp_char` and `out_char` are 0.
- `dp_start`, `out_valid` and `err` are 0.

## Timing

- LOAD, NOP and RESET_POS take effect on the accepting edge, with zero extra latency.
- ENCRYPT, with the accepting edge as E0:
  - new positions are visible after E1;
  - `dp_start` is high between E1 and E2;
  - `dp_result` is sampled at edge E(2+DP_LATENCY);
  - `out_valid` is high for the cycle after that edge.
- Throughput is one character per 2+DP_LATENCY cycles.
- While busy, a held `cmd_valid` is not consumed. The command waits until `cmd_ready` returns.
- Reset asserted mid-operation clears all state immediately. No `out_valid` is produced for the aborted character.
- `err` is set at the edge accepting the offending command. It clears only via RESET_POS or `rst_n`.

## Test plan

1. **First character.** After reset, ENCRYPT 0 with the stub returning 7 (DP_LATENCY=2):
   - `dp_start` is high with positions l/m/r = 0/0/1;
   - `out_char`=7 and `out_valid` pulses for one cycle, 4 edges after accept.
2. **Right-notch turnover.** LOAD_R 21, LOAD_M 0, then ENCRYPT → positions l/m/r = 0/1/22.
3. **Double-step.** LOAD_L 0, LOAD_M 3, LOAD_R 21, then ENCRYPT → 0/4/22. A second ENCRYPT → 1/5/23.
4. **Wrap.** LOAD_R 25, LOAD_M 25 (not at notch), then ENCRYPT → R=0, M=25.
5. **Errors.**
   - LOAD_R 26 → `err`=1 and R unchanged.
   - Op 6 → `err` stays 1.
   - RESET_POS → `err`=0 and all positions 0.
6. **Backpressure and reset.**
   - `cmd_valid` held through a busy ENCRYPT is accepted exactly once, in the `out_valid` cycle.
   - `rst_n` pulsed low during WAIT → no `out_valid`, all positions 0, `cmd_ready`=1.
